// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage; owns the PC, reads inst_mem, buffers {pc, inst} toward decode
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_addr / imem_inst    word address to inst_mem (from pc) / same-cycle instruction
//   redirect_valid/_pc       PC change request from execute; flushes the buffer
//   id_valid/id_ready        valid/ready handshake toward decode
//   id_inst / id_pc          head entry, zero when the buffer is empty
// Build option FETCH_PERF_EN adds perf_stall_cnt and perf_flush_cnt (saturating).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] pc;
  logic [31:0] q_pc [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic full, pop, push;
  assign full = count == CW'(DEPTH);
  assign pop = id_valid & id_ready;
  // a full buffer can still take a new entry in the cycle its head leaves
  assign push = ~redirect_valid & (~full | pop);
  assign imem_addr = pc[ADDR_W-1:0];
  assign id_valid = count != '0;
  assign id_inst = id_valid ? q_inst[rd_ptr] : '0;
  assign id_pc = id_valid ? q_pc[rd_ptr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc <= pc + 32'd1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // payload needs no reset: it is only visible through a nonzero count
  always_ff @(posedge clk)
    if (push) begin
      q_pc[wr_ptr] <= pc;
      q_inst[wr_ptr] <= imem_inst;
    end
`ifdef FETCH_PERF_EN
  logic stall_ev, flush_ev;
  assign stall_ev = full & ~id_ready;
  // an entry popped during the redirect cycle was consumed, not discarded
  assign flush_ev = redirect_valid & (count > CW'(pop));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_ev && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_ev && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a queue-based fetch model
module tb_fetch_stage;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] imem_addr;
  logic [31:0] imem_inst;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic id_valid;
  logic id_ready = 1'b0;
  logic [31:0] id_inst, id_pc;
  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  fetch_stage #(.RESET_PC(32'd0), .ADDR_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign imem_inst = mem[imem_addr];
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];
  logic [31:0] m_pc;
  int m_stall, m_flush;
  typedef struct {
    bit r; bit v; logic [31:0] rpc;
    bit ev; logic [31:0] epc; logic [7:0] eaddr;
  } tv_t;
  tv_t tv [25];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_pc = 32'd0;
    m_stall = 0;
    m_flush = 0;
  endtask
  task automatic model_update(input bit r, input bit v, input logic [31:0] p);
    int pop;
    pop = (q.size() != 0 && r) ? 1 : 0;
    if (q.size() == DEPTH && !r) m_stall++;
    if (v) begin
      if (q.size() - pop > 0) m_flush++;
      q.delete();
      m_pc = p;
    end else begin
      if (pop != 0) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back('{m_pc, mem[m_pc[7:0]]});
        m_pc = m_pc + 32'd1;
      end
    end
  endtask
  task automatic model_check();
    bit v;
    v = q.size() != 0;
    chk("id_valid", {31'd0, id_valid}, {31'd0, v});
    chk("id_pc", id_pc, v ? q[0].pc : 32'd0);
    chk("id_inst", id_inst, v ? q[0].inst : 32'd0);
    chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc[7:0]});
`ifdef FETCH_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
    chk("perf_flush_cnt", perf_flush_cnt, m_flush);
`endif
  endtask
  task automatic step(input bit r, input bit v, input logic [31:0] p);
    id_ready = r;
    redirect_valid = v;
    redirect_pc = p;
    @(posedge clk);
    model_update(r, v, p);
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'hA0A0_0001;
    mem[1] = 32'hB0B0_0002;
    mem[2] = 32'hC0C0_0003;
    mem[3] = 32'hD0D0_0004;
    tv[0]  = '{1, 0, 0,   0, 0,   0};
    tv[1]  = '{1, 0, 0,   1, 0,   1};
    tv[2]  = '{1, 0, 0,   1, 1,   2};
    tv[3]  = '{1, 0, 0,   1, 2,   3};
    tv[4]  = '{1, 0, 0,   1, 3,   4};
    tv[5]  = '{0, 1, 0,   1, 4,   5};
    tv[6]  = '{0, 0, 0,   0, 0,   0};
    tv[7]  = '{0, 0, 0,   1, 0,   1};
    tv[8]  = '{0, 0, 0,   1, 0,   2};
    tv[9]  = '{0, 0, 0,   1, 0,   2};
    tv[10] = '{0, 0, 0,   1, 0,   2};
    tv[11] = '{1, 0, 0,   1, 0,   2};
    tv[12] = '{1, 0, 0,   1, 1,   3};
    tv[13] = '{1, 0, 0,   1, 2,   4};
    tv[14] = '{0, 1, 40,  1, 3,   5};
    tv[15] = '{1, 0, 0,   0, 0,   40};
    tv[16] = '{1, 0, 0,   1, 40,  41};
    tv[17] = '{1, 1, 254, 1, 41,  42};
    tv[18] = '{1, 0, 0,   0, 0,   254};
    tv[19] = '{1, 0, 0,   1, 254, 255};
    tv[20] = '{1, 0, 0,   1, 255, 0};
    tv[21] = '{0, 0, 0,   1, 256, 1};
    tv[22] = '{1, 1, 100, 1, 256, 2};
    tv[23] = '{0, 0, 0,   0, 0,   100};
    tv[24] = '{0, 0, 0,   1, 100, 101};
    model_reset();
    @(negedge clk);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("tv%0d_valid", i), {31'd0, id_valid}, {31'd0, tv[i].ev});
      chk($sformatf("tv%0d_pc", i), id_pc, tv[i].ev ? tv[i].epc : 32'd0);
      chk($sformatf("tv%0d_inst", i), id_inst, tv[i].ev ? mem[tv[i].epc[7:0]] : 32'd0);
      chk($sformatf("tv%0d_addr", i), {24'd0, imem_addr}, {24'd0, tv[i].eaddr});
      step(tv[i].r, tv[i].v, tv[i].rpc);
    end
    model_check();
    step(1, 1, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) begin
      model_check();
      step(1, 0, 0);
    end
    for (int i = 0; i < 600; i++) begin
      logic [31:0] p;
      case ($urandom_range(0, 3))
        0: p = 32'hFFFF_FFFD;
        1: p = 32'd253;
        default: p = $urandom;
      endcase
      model_check();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, p);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    model_check();
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, id_valid}, 32'd0);
    chk("midrst_pc", id_pc, 32'd0);
    chk("midrst_inst", id_inst, 32'd0);
    chk("midrst_addr", {24'd0, imem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      model_check();
      step(1, 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
